// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package rf_wb_pkg;

   localparam int REG_ADDR_W    = 5;
   localparam int REG_WIDTH_DEF = 32;
   localparam int MAX_NUM_REQ   = 8;

   typedef logic [REG_ADDR_W-1:0] rf_addr_t;

   typedef struct packed {
      logic                     valid;
      rf_addr_t                 rd;
      logic [REG_WIDTH_DEF-1:0] data;
   } wb_req_t;

   // Width of an index into n requesters (at least one bit).
   function automatic int idx_w(int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// One-hot requester arbiter. Round-robin by default; with
// RF_WB_ARB_FIXED_PRIO_EN defined it becomes fixed priority (lowest index
// wins) and the pointer register is dropped.
module rr_arbiter
   import rf_wb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

`ifdef RF_WB_ARB_FIXED_PRIO_EN

   logic unused_ok;
   assign unused_ok = ^{clk, reset, advance};

   // Lowest-index requester wins.
   always_comb begin
      logic found;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

`else

   localparam int PW = idx_w(N);

   logic [PW-1:0] ptr_q, ptr_d;

   // Search starts just above the last winner, then wraps to index 0.
   always_comb begin
      logic found;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i > int'(ptr_q))) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   // Pointer follows the winner of an accepted transfer, otherwise holds.
   always_comb begin
      ptr_d = ptr_q;
      for (int i = 0; i < N; i++) begin
         if (advance && gnt[i]) ptr_d = PW'(i);
      end
   end

   // Pointer register; reset value gives requester 0 first priority.
   always_ff @(posedge clk) begin
      if (reset) ptr_q <= PW'(N-1);
      else       ptr_q <= ptr_d;
   end

`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter: one-hot grant over the writeback
// requesters, a registered write stage (latency 1) and x0 suppression.
// Optional macro: RF_WB_ARB_FIXED_PRIO_EN selects fixed priority.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int REG_WIDTH = 32,
   parameter int NUM_REQ   = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_rd,
   input  logic [NUM_REQ*REG_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [REG_ADDR_W-1:0]          rf_rd,
   output logic [REG_WIDTH-1:0]           rf_rd_din,
   output logic                           rf_reg_write,
   output logic                           wb_busy
);

   logic [NUM_REQ-1:0]   vld_m;
   logic [NUM_REQ-1:0]   gnt;
   logic                 xfer;
   rf_addr_t             sel_rd;
   logic [REG_WIDTH-1:0] sel_data;

   rf_addr_t             rd_q, rd_d;
   logic [REG_WIDTH-1:0] din_q, din_d;
   logic                 we_q, we_d;

   // Nothing is granted while reset is held.
   assign vld_m = reset ? '0 : req_valid;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (vld_m),
      .advance (xfer),
      .gnt     (gnt)
   );

   assign req_ready = gnt;
   assign xfer      = |gnt;
   assign wb_busy   = !reset && ($countones(req_valid) >= 2);

   // One-hot mux of the winning requester's destination and data.
   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_rd   = sel_rd   | (req_rd[REG_ADDR_W*i +: REG_ADDR_W] & {REG_ADDR_W{gnt[i]}});
         sel_data = sel_data | (req_data[REG_WIDTH*i +: REG_WIDTH] & {REG_WIDTH{gnt[i]}});
      end
   end

   // Stage the accepted write; x0 is taken but never written.
   always_comb begin
      rd_d  = rd_q;
      din_d = din_q;
      we_d  = 1'b0;
      if (xfer) begin
         rd_d  = sel_rd;
         din_d = sel_data;
         we_d  = (sel_rd != '0);
      end
   end

   // Write stage register; reset drops any staged write.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q  <= '0;
         din_q <= '0;
         we_q  <= 1'b0;
      end else begin
         rd_q  <= rd_d;
         din_q <= din_d;
         we_q  <= we_d;
      end
   end

   assign rf_rd        = rd_q;
   assign rf_rd_din    = din_q;
   assign rf_reg_write = we_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by
// randomized traffic, compared against a cycle-level reference model.
module tb_rf_wb_arbiter;

   localparam int N = 3;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*5-1:0] req_rd;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic [4:0]     rf_rd;
   logic [W-1:0]   rf_rd_din;
   logic           rf_reg_write;
   logic           wb_busy;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.REG_WIDTH(W), .NUM_REQ(N)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_rd       (req_rd),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .rf_rd        (rf_rd),
      .rf_rd_din    (rf_rd_din),
      .rf_reg_write (rf_reg_write),
      .wb_busy      (wb_busy)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state
   int         ptr;
   logic       exp_we;
   logic [4:0] exp_rd;
   logic [W-1:0] exp_din;
   bit         drop_on_grant;
   int         wait_cnt [N];
   logic [N-1:0] obs_ready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Which requester should win this cycle, or -1.
   function automatic int model_grant(input logic [N-1:0] v);
`ifdef RF_WB_ARB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++)
         if (((v >> k) & 1) != 0) return k;
`else
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (ptr + k) % N;
         if (((v >> idx) & 1) != 0) return idx;
      end
`endif
      return -1;
   endfunction

   task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [W-1:0] d);
      req_valid[i]       = v;
      req_rd[5*i +: 5]   = rd;
      req_data[W*i +: W] = d;
   endtask

   // One clock: check at negedge, advance model at posedge, drive at +1.
   task automatic step();
      int g;
      int nv;
      logic [N-1:0] er;
      logic [4:0]   grd;
      logic [W-1:0] gdat;
      @(negedge clk);
      g  = reset ? -1 : model_grant(req_valid);
      er = '0;
      if (g >= 0) er = N'(1) << g;
      nv = 0;
      for (int i = 0; i < N; i++) if (req_valid[i]) nv++;
      obs_ready = req_ready;
      chk("req_ready",    64'(req_ready),    64'(er));
      chk("wb_busy",      64'(wb_busy),      64'(!reset && nv >= 2));
      chk("rf_reg_write", 64'(rf_reg_write), 64'(exp_we));
      chk("rf_rd",        64'(rf_rd),        64'(exp_rd));
      chk("rf_rd_din",    64'(rf_rd_din),    64'(exp_din));
`ifndef RF_WB_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) begin
         if (!reset && req_valid[i] && !req_ready[i]) begin
            wait_cnt[i]++;
            chk("starvation", 64'(wait_cnt[i] < N), 64'(1));
         end else begin
            wait_cnt[i] = 0;
         end
      end
`endif
      @(posedge clk);
      if (reset) begin
         ptr = N-1; exp_we = 1'b0; exp_rd = '0; exp_din = '0;
      end else if (g >= 0) begin
         grd     = 5'(req_rd >> (5*g));
         gdat    = W'(req_data >> (W*g));
         ptr     = g;
         exp_we  = (grd != 5'd0);
         exp_rd  = grd;
         exp_din = gdat;
      end else begin
         exp_we = 1'b0;
      end
      #1;
      if (drop_on_grant && g >= 0) req_valid[g] = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
      ptr = N-1; exp_we = 1'b0; exp_rd = '0; exp_din = '0;
      drop_on_grant = 1'b1;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      #1;
      step(); step();
      reset = 1'b0;

      // Single requester, latency 1 then idle
      set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
      step();
      chk("single_grant", 64'(obs_ready), 64'(3'b001));
      step(); step();

      // All requesters continuously valid after reset
      reset = 1'b1; step(); reset = 1'b0;
      drop_on_grant = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i+1), 32'hA0 + 32'(i));
      repeat (7) step();
      req_valid = '0; drop_on_grant = 1'b1;
      step();

      // x0 write accepted, pointer moves past requester 1
      set_req(1, 1'b1, 5'd0, 32'h1234);
      step();
      set_req(0, 1'b1, 5'd9,  32'h9999);
      set_req(2, 1'b1, 5'd10, 32'hAAAA);
      step();
`ifdef RF_WB_ARB_FIXED_PRIO_EN
      chk("after_x0_grant", 64'(obs_ready), 64'(3'b001));
`else
      chk("after_x0_grant", 64'(obs_ready), 64'(3'b100));
`endif
      step(); step();

      // Same destination from two requesters
      set_req(0, 1'b1, 5'd7, 32'hAAAA_0000);
      set_req(2, 1'b1, 5'd7, 32'hBBBB_0000);
      step(); step(); step();
`ifdef RF_WB_ARB_FIXED_PRIO_EN
      chk("same_rd_final", 64'(rf_rd_din), 64'(32'hBBBB_0000));
`else
      chk("same_rd_final", 64'(rf_rd_din), 64'(32'hAAAA_0000));
`endif
      step();

      // Reset in the cycle after a transfer
      set_req(1, 1'b1, 5'd4, 32'h55);
      step();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(11+i), 32'hC0 + 32'(i));
      step();
      chk("post_reset_first", 64'(obs_ready), 64'(3'b001));
      repeat (4) step();

      // Randomized traffic honouring the hold-while-waiting rule
      for (int c = 0; c < 400; c++) begin
         reset = ($urandom_range(0, 63) == 0);
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 2) != 0)
               set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
         step();
      end
      reset = 1'b0;
      req_valid = '0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
